fft_bin_power_reader: RTL

- Downstream stage of the FFT-to-BRAM writer; consumes the 256-bin x 8-mic complex spectrum that the writer leaves in the real and imaginary BRAMs.
- Starts on the writer's `finish` pulse and reads the BRAMs through Port B.
- For each bin, computes the total power across mics: sum over the 8 mics of (re^2 + im^2).
- Streams 256 power words on AXI-Stream to the beamforming/detection logic, then pulses `rearm` to restart the writer.

---
 rtl/fft_bin_power_reader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fft_bin_power_reader.sv
// Reads the 256-bin x 8-mic complex spectrum from the writer's BRAMs and streams
// per-bin total power (sum over mics of re^2 + im^2) on AXI-Stream, then rearms the writer.
module fft_bin_power_reader #(
  parameter int N_BINS   = 256,
  parameter int N_MICS   = 8,
  parameter int RD_LAT   = 1,
  parameter int SAMPLE_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fft_done,
  output logic [31:0] bram_addr,
  output logic        bram_en,
  input  logic [31:0] bram_dout_re,
  input  logic [31:0] bram_dout_im,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        rearm,
  output logic        busy
);

  localparam int BIN_W   = $clog2(N_BINS);
  localparam int MIC_W   = $clog2(N_MICS);
  localparam int DRAIN_W = $clog2(RD_LAT + 3);
  localparam int SQ_W    = 2 * SAMPLE_W;
  localparam int ACC_W   = SQ_W + MIC_W;

  localparam logic [BIN_W-1:0]   LAST_BIN  = BIN_W'(N_BINS - 1);
  localparam logic [MIC_W-1:0]   LAST_MIC  = MIC_W'(N_MICS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRN  = DRAIN_W'(RD_LAT + 1);

  // Handshake: a beat transfers on a cycle with m_axis_tvalid && m_axis_tready;
  // tvalid never waits on tready, and tdata/tlast hold until the transfer.

  typedef enum logic [2:0] {IDLE, READ, DRAIN, OUT, REARM} state_t;

  state_t               state;
  logic [BIN_W-1:0]     bin;
  logic [MIC_W-1:0]     mic;
  logic [DRAIN_W-1:0]   drain_cnt;

  logic [RD_LAT-1:0]            rd_sh;
  logic signed [SAMPLE_W-1:0]   cap_re, cap_im;
  logic                         cap_v;
  logic [SQ_W-1:0]              sq;
  logic                         sq_v;
  logic [ACC_W-1:0]             acc;

  logic signed [SQ_W-1:0] re_x, im_x, re_sq, im_sq;
  logic                   unused_hi_bits;

  assign unused_hi_bits = ^{bram_dout_re[31:SAMPLE_W], bram_dout_im[31:SAMPLE_W]};

  assign re_x  = SQ_W'(cap_re);
  assign im_x  = SQ_W'(cap_im);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  assign m_axis_tdata = 64'(acc);

  function automatic logic [31:0] word_addr(input logic [BIN_W-1:0] b,
                                            input logic [MIC_W-1:0] m);
    return (32'(b) * 32'(N_MICS) + 32'(m)) << 2;
  endfunction

  // Capture -> square -> accumulate; rd_sh marks which cycles carry read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sh  <= '0;
      cap_re <= '0;
      cap_im <= '0;
      cap_v  <= 1'b0;
      sq     <= '0;
      sq_v   <= 1'b0;
      acc    <= '0;
    end else begin
      rd_sh[0] <= bram_en;
      for (int i = 1; i < RD_LAT; i++) rd_sh[i] <= rd_sh[i-1];
      cap_v <= rd_sh[RD_LAT-1];
      if (rd_sh[RD_LAT-1]) begin
        cap_re <= bram_dout_re[SAMPLE_W-1:0];
        cap_im <= bram_dout_im[SAMPLE_W-1:0];
      end
      sq_v <= cap_v;
      if (cap_v) sq <= $unsigned(re_sq) + $unsigned(im_sq);
      if (state == READ && mic == '0) acc <= '0;
      else if (sq_v)                  acc <= acc + ACC_W'(sq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bin           <= '0;
      mic           <= '0;
      drain_cnt     <= '0;
      bram_en       <= 1'b0;
      bram_addr     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      rearm         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fft_done) begin
            state     <= READ;
            bin       <= '0;
            mic       <= '0;
            busy      <= 1'b1;
            bram_en   <= 1'b1;
            bram_addr <= word_addr('0, '0);
          end
        end
        READ: begin
          if (mic == LAST_MIC) begin
            state     <= DRAIN;
            bram_en   <= 1'b0;
            drain_cnt <= '0;
          end else begin
            mic       <= mic + 1'b1;
            bram_addr <= word_addr(bin, mic + 1'b1);
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRN) begin
            state         <= OUT;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (bin == LAST_BIN);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            if (bin == LAST_BIN) begin
              state <= REARM;
              rearm <= 1'b1;
            end else begin
              state     <= READ;
              bin       <= bin + 1'b1;
              mic       <= '0;
              bram_en   <= 1'b1;
              bram_addr <= word_addr(bin + 1'b1, '0);
            end
          end
        end
        REARM: begin
          rearm <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
